// File: rtl/adder_tree_feeder.sv
// Source/sink wrapper around an 8-input pipelined adder tree.
// Packs a byte stream into 8 lanes, launches the vector, then captures the
// tree's result LATENCY cycles later and compares it against a locally
// accumulated reference sum.
module adder_tree_feeder #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] lane0,
  output logic [WIDTH-1:0] lane1,
  output logic [WIDTH-1:0] lane2,
  output logic [WIDTH-1:0] lane3,
  output logic [WIDTH-1:0] lane4,
  output logic [WIDTH-1:0] lane5,
  output logic [WIDTH-1:0] lane6,
  output logic [WIDTH-1:0] lane7,
  output logic             launch,
  input  logic [WIDTH-1:0] sum_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             sum_valid,
  output logic             mismatch,
  output logic [15:0]      vec_count
);

  logic [2:0]       idx_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shadow_reg [0:6];
  logic [WIDTH-1:0] lanes_reg  [0:7];
  logic             launch_reg;
  logic [WIDTH-1:0] ref_reg;
  logic [LATENCY-1:0] launch_pipe;
  logic [WIDTH-1:0] ref_pipe [0:LATENCY-1];
  logic             accept;
  logic             take;
  logic             complete;

  // Ready depends only on enable and reset, never on s_valid.
  assign s_ready  = en & ~rst;
  assign accept   = s_valid & s_ready;
  // A byte arriving together with flush is dropped.
  assign take     = accept & ~flush;
  assign complete = take & (idx_reg == 3'd7);
  assign acc_next = acc_reg + s_data;

  // Slot index and running reference sum for the vector being collected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= 3'd0;
      acc_reg <= '0;
    end else if (flush) begin
      idx_reg <= 3'd0;
      acc_reg <= '0;
    end else if (take) begin
      idx_reg <= idx_reg + 3'd1;
      acc_reg <= complete ? '0 : acc_next;
    end
  end

  // Shadow slots 0..6; byte 7 goes straight to lane7 on completion.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_shadow
      // Capture byte gi into its shadow slot.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          shadow_reg[gi] <= '0;
        else if (take && idx_reg == 3'(gi))
          shadow_reg[gi] <= s_data;
      end
    end
  endgenerate

  // Lanes update only on completion and hold otherwise; launch is a 1-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) lanes_reg[i] <= '0;
      launch_reg <= 1'b0;
      ref_reg    <= '0;
    end else begin
      launch_reg <= complete;
      if (complete) begin
        for (int i = 0; i < 7; i++) lanes_reg[i] <= shadow_reg[i];
        lanes_reg[7] <= s_data;
        ref_reg      <= acc_next;
      end
    end
  end

  // Launch and reference travel in lockstep with the adder pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      launch_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) ref_pipe[i] <= '0;
    end else begin
      launch_pipe[0] <= launch_reg;
      ref_pipe[0]    <= ref_reg;
      for (int i = 1; i < LATENCY; i++) begin
        launch_pipe[i] <= launch_pipe[i-1];
        ref_pipe[i]    <= ref_pipe[i-1];
      end
    end
  end

  // Capture the tree result, count it, and latch any disagreement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_out   <= '0;
      sum_valid <= 1'b0;
      mismatch  <= 1'b0;
      vec_count <= 16'd0;
    end else begin
      sum_valid <= launch_pipe[LATENCY-1];
      if (launch_pipe[LATENCY-1]) begin
        sum_out   <= sum_in;
        vec_count <= vec_count + 16'd1;
        if (sum_in != ref_pipe[LATENCY-1])
          mismatch <= 1'b1;
      end
    end
  end

  assign lane0  = lanes_reg[0];
  assign lane1  = lanes_reg[1];
  assign lane2  = lanes_reg[2];
  assign lane3  = lanes_reg[3];
  assign lane4  = lanes_reg[4];
  assign lane5  = lanes_reg[5];
  assign lane6  = lanes_reg[6];
  assign lane7  = lanes_reg[7];
  assign launch = launch_reg;

endmodule
